// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, flag indices, issue FSM states and latency lookup
package alu_pkg;
    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_MUL = 4'd2;
    localparam logic [3:0] OP_DIV = 4'd3;
    localparam logic [3:0] OP_MOD = 4'd4;
    localparam logic [3:0] OP_MOV = 4'd5;
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
    // Illegal opcodes fall through to the fast latency
    function automatic int op_latency(input logic [3:0] op, input int lat_fast, input int lat_mul, input int lat_div);
        return (op == OP_MUL) ? lat_mul : (op == OP_DIV || op == OP_MOD) ? lat_div : lat_fast;
    endfunction
endpackage

// File: rtl/alu_issue_ctrl_if.sv
// alu_issue_ctrl_if: request, ALU operand/result and response channels
interface alu_issue_ctrl_if #(parameter int N = 32, parameter int TAG_W = 4);
    logic             flush;
    logic             req_valid;
    logic             req_ready;
    logic [3:0]       req_op;
    logic [N-1:0]     req_a;
    logic [N-1:0]     req_b;
    logic             req_set_flags;
    logic [TAG_W-1:0] req_tag;
    logic [N-1:0]     alu_a;
    logic [N-1:0]     alu_b;
    logic [3:0]       alu_op;
    logic [N-1:0]     alu_result;
    logic [3:0]       alu_flags;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [N-1:0]     rsp_result;
    logic [3:0]       rsp_flags;
    logic [TAG_W-1:0] rsp_tag;
    logic             rsp_err;
    logic [3:0]       flags_q;
    modport master (
        input  flush, req_valid, req_op, req_a, req_b, req_set_flags, req_tag,
               alu_result, alu_flags, rsp_ready,
        output req_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_result, rsp_flags,
               rsp_tag, rsp_err, flags_q
    );
    modport slave (
        output flush, req_valid, req_op, req_a, req_b, req_set_flags, req_tag,
               alu_result, alu_flags, rsp_ready,
        input  req_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_result, rsp_flags,
               rsp_tag, rsp_err, flags_q
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issues one op to the combinational ALU, waits its latency, returns result and NZCV
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int N        = 32,
    parameter int TAG_W    = 4,
    parameter int LAT_FAST = 1,
    parameter int LAT_MUL  = 2,
    parameter int LAT_DIV  = 4
) (
    input logic clk,
    input logic rst_n,
    alu_issue_ctrl_if.master bus
);
    localparam int LMAX1 = (LAT_FAST > LAT_MUL) ? LAT_FAST : LAT_MUL;
    localparam int LMAX  = (LMAX1 > LAT_DIV) ? LMAX1 : LAT_DIV;
    localparam int CW    = $clog2(LMAX) + 1;

    state_t           r_state, w_next;
    logic [CW-1:0]    r_cnt;
    logic [N-1:0]     r_alu_a, r_alu_b, r_result;
    logic [3:0]       r_alu_op, r_flags, r_flags_q;
    logic [TAG_W-1:0] r_tag;
    logic             r_set_flags, r_err;
    logic             w_accept, w_capture, w_err;
    logic [CW-1:0]    w_lat_m1;

    assign w_accept  = (r_state == IDLE) && bus.req_valid && !bus.flush;
    assign w_capture = (r_state == EXEC) && (r_cnt == '0) && !bus.flush;
    // Error is judged from the held operands, so no extra state is needed
    assign w_err     = (r_alu_op > OP_MOV) || ((r_alu_op == OP_DIV || r_alu_op == OP_MOD) && r_alu_b == '0);
    assign w_lat_m1  = CW'(op_latency(bus.req_op, LAT_FAST, LAT_MUL, LAT_DIV) - 1);

    // Next state: flush wins over everything, then accept, capture, response handshake
    always_comb begin
        w_next = r_state;
        w_next = bus.flush ? IDLE :
                 w_accept ? EXEC :
                 w_capture ? DONE :
                 (r_state == DONE && bus.rsp_ready) ? IDLE : r_state;
    end

    // State, operand, counter and response registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_op    <= 4'b0000;
            r_tag       <= '0;
            r_set_flags <= 1'b0;
            r_result    <= '0;
            r_flags     <= 4'b0000;
            r_err       <= 1'b0;
            r_flags_q   <= 4'b0000;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_alu_a     <= bus.req_a;
                r_alu_b     <= bus.req_b;
                r_alu_op    <= bus.req_op;
                r_tag       <= bus.req_tag;
                r_set_flags <= bus.req_set_flags;
                r_cnt       <= w_lat_m1;
            end else if (r_state == EXEC && !bus.flush && r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_capture) begin
                r_result <= w_err ? '0 : bus.alu_result;
                r_flags  <= w_err ? 4'b0000 : bus.alu_flags;
                r_err    <= w_err;
                if (r_set_flags && !w_err) r_flags_q <= bus.alu_flags;
            end
        end
    end

    assign bus.req_ready  = (r_state == IDLE);
    assign bus.rsp_valid  = (r_state == DONE);
    assign bus.alu_a      = r_alu_a;
    assign bus.alu_b      = r_alu_b;
    assign bus.alu_op     = r_alu_op;
    assign bus.rsp_result = r_result;
    assign bus.rsp_flags  = r_flags;
    assign bus.rsp_tag    = r_tag;
    assign bus.rsp_err    = r_err;
    assign bus.flags_q    = r_flags_q;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: randomized self-checking bench against an opcode-level reference model
module tb_alu_issue_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_pass = 0;
    int n_tot = 0;
    logic [3:0] m_flags = 4'b0000;
    logic [31:0] last_a = 32'd0;

    alu_issue_ctrl_if #(.N(32), .TAG_W(4)) bus ();
    alu_issue_ctrl #(.N(32), .TAG_W(4), .LAT_FAST(1), .LAT_MUL(2), .LAT_DIV(4)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    always #5 clk = ~clk;

    // Arithmetic meaning of each opcode: {N,Z,C,V, result}
    function automatic logic [35:0] alu_eval(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [32:0] w;
        logic [31:0] r;
        logic c, v;
        w = 33'd0; c = 1'b0; v = 1'b0;
        case (op)
            4'd0: begin w = {1'b0, a} + {1'b0, b}; c = w[32]; end
            4'd1: begin w = {1'b0, a} - {1'b0, b}; c = (a >= b); end
            4'd2: w = {1'b0, a * b};
            4'd3: w = {1'b0, (b == 0) ? 32'd0 : a / b};
            4'd4: w = {1'b0, (b == 0) ? 32'd0 : a % b};
            4'd5: w = {1'b0, b};
            default: w = 33'd0;
        endcase
        r = w[31:0];
        if (op == 4'd0) v = (a[31] == b[31]) && (r[31] != a[31]);
        if (op == 4'd1) v = (a[31] != b[31]) && (r[31] != a[31]);
        return {r[31], r == 32'd0, c, v, r};
    endfunction

    // Environment ALU feeding the block
    always_comb begin
        bus.alu_result = alu_eval(bus.alu_op, bus.alu_a, bus.alu_b)[31:0];
        bus.alu_flags  = alu_eval(bus.alu_op, bus.alu_a, bus.alu_b)[35:32];
    end

    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic sf, input logic [3:0] tag, input int stall);
        logic [35:0] ev;
        logic err, busy_ok, stable_ok;
        logic [31:0] er;
        logic [3:0] ef;
        int lat, c;
        err = (op > 4'd5) || ((op == 4'd3 || op == 4'd4) && b == 32'd0);
        lat = (op == 4'd2) ? 2 : (op == 4'd3 || op == 4'd4) ? 4 : 1;
        ev = alu_eval(op, a, b);
        er = err ? 32'd0 : ev[31:0];
        ef = err ? 4'd0 : ev[35:32];
        if (sf && !err) m_flags = ef;
        @(negedge clk);
        n_tot++;
        if (bus.req_ready !== 1'b1) $display("FAIL idle_ready: got %b want 1", bus.req_ready); else n_pass++;
        bus.req_valid = 1'b1; bus.req_op = op; bus.req_a = a; bus.req_b = b;
        bus.req_set_flags = sf; bus.req_tag = tag;
        @(negedge clk);
        bus.req_valid = 1'b0; bus.req_a = $urandom; bus.req_b = $urandom; bus.req_op = 4'($urandom);
        last_a = a;
        c = 0;
        busy_ok = 1'b1;
        while (bus.rsp_valid !== 1'b1 && c < 20) begin
            busy_ok &= (bus.req_ready === 1'b0) && (bus.alu_a === a) && (bus.alu_op === op);
            @(negedge clk);
            c++;
        end
        n_tot++;
        if (c != lat) $display("FAIL latency op=%0d: got %0d want %0d", op, c, lat); else n_pass++;
        n_tot++;
        if (!busy_ok) $display("FAIL exec_hold op=%0d: ready/operands changed while busy", op); else n_pass++;
        n_tot++;
        if ({bus.rsp_result, bus.rsp_flags, bus.rsp_tag, bus.rsp_err} !== {er, ef, tag, err})
            $display("FAIL response op=%0d: got res=%h fl=%b tag=%h err=%b want res=%h fl=%b tag=%h err=%b",
                     op, bus.rsp_result, bus.rsp_flags, bus.rsp_tag, bus.rsp_err, er, ef, tag, err);
        else n_pass++;
        n_tot++;
        if (bus.flags_q !== m_flags) $display("FAIL flags_q op=%0d: got %b want %b", op, bus.flags_q, m_flags); else n_pass++;
        stable_ok = 1'b1;
        repeat (stall) begin
            @(negedge clk);
            stable_ok &= (bus.rsp_valid === 1'b1) && (bus.req_ready === 1'b0) &&
                         ({bus.rsp_result, bus.rsp_flags, bus.rsp_tag, bus.rsp_err} === {er, ef, tag, err});
        end
        n_tot++;
        if (!stable_ok) $display("FAIL backpressure op=%0d: response not held for %0d cycles", op, stall); else n_pass++;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        n_tot++;
        if ({bus.rsp_valid, bus.req_ready} !== 2'b01)
            $display("FAIL handshake_return: got valid/ready=%b%b want 01", bus.rsp_valid, bus.req_ready);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.req_valid = 1'b1; bus.req_op = 4'd2; bus.req_a = 32'hDEAD_BEEF; bus.req_b = 32'h5;
        repeat (3) @(negedge clk);
        n_tot++;
        if ({bus.rsp_valid, bus.flags_q, bus.alu_a, bus.alu_op, bus.rsp_result, bus.rsp_err} !== {1'b0, 4'd0, 32'd0, 4'd0, 32'd0, 1'b0})
            $display("FAIL reset_values: got valid=%b fq=%b a=%h op=%h res=%h err=%b want all zero",
                     bus.rsp_valid, bus.flags_q, bus.alu_a, bus.alu_op, bus.rsp_result, bus.rsp_err);
        else n_pass++;
        bus.req_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        n_tot++;
        if ({bus.req_ready, bus.rsp_valid, bus.alu_a} !== {1'b1, 1'b0, 32'd0})
            $display("FAIL reset_release: got ready=%b valid=%b a=%h want 1 0 0", bus.req_ready, bus.rsp_valid, bus.alu_a);
        else n_pass++;
    endtask

    task automatic test_add();
        run_op(4'd0, 32'd5, 32'd3, 1'b1, 4'd7, 0);
    endtask

    task automatic test_sub();
        run_op(4'd1, 32'd3, 32'd5, 1'b1, 4'd2, 1);
        n_tot++;
        if (bus.flags_q[3] !== 1'b1) $display("FAIL sub_negative: got N=%b want 1", bus.flags_q[3]); else n_pass++;
    endtask

    task automatic test_div();
        run_op(4'd3, 32'd100, 32'd7, 1'b0, 4'd3, 0);
        run_op(4'd4, 32'd100, 32'd0, 1'b1, 4'd4, 0);
    endtask

    task automatic test_backpressure();
        run_op(4'd2, 32'd6, 32'd7, 1'b1, 4'd9, 5);
    endtask

    task automatic test_flush();
        logic ok;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_op = 4'd3; bus.req_a = 32'd50; bus.req_b = 32'd5;
        bus.req_set_flags = 1'b1; bus.req_tag = 4'd1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        last_a = 32'd50;
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        n_tot++;
        if ({bus.req_ready, bus.rsp_valid, bus.flags_q} !== {1'b1, 1'b0, m_flags})
            $display("FAIL flush_exec: got ready=%b valid=%b fq=%b want 1 0 %b", bus.req_ready, bus.rsp_valid, bus.flags_q, m_flags);
        else n_pass++;
        ok = 1'b1;
        repeat (6) begin
            @(negedge clk);
            ok &= (bus.rsp_valid === 1'b0);
        end
        n_tot++;
        if (!ok) $display("FAIL flush_discard: got late rsp_valid want none"); else n_pass++;
        bus.req_valid = 1'b1; bus.flush = 1'b1; bus.req_a = 32'h1234_5678; bus.req_op = 4'd0;
        @(negedge clk);
        bus.req_valid = 1'b0; bus.flush = 1'b0;
        @(negedge clk);
        n_tot++;
        if ({bus.req_ready, bus.rsp_valid, bus.alu_a} !== {1'b1, 1'b0, last_a})
            $display("FAIL flush_idle: got ready=%b valid=%b a=%h want 1 0 %h", bus.req_ready, bus.rsp_valid, bus.alu_a, last_a);
        else n_pass++;
    endtask

    task automatic test_illegal();
        run_op(4'd9, 32'd11, 32'd22, 1'b1, 4'd5, 0);
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_op = 4'd4; bus.req_a = 32'd77; bus.req_b = 32'd6;
        bus.req_set_flags = 1'b1; bus.req_tag = 4'd6;
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_tot++;
        if ({bus.req_ready, bus.rsp_valid, bus.alu_a, bus.flags_q, bus.rsp_tag} !== {1'b1, 1'b0, 32'd0, 4'd0, 4'd0})
            $display("FAIL async_reset: got ready=%b valid=%b a=%h fq=%b tag=%h want 1 0 0 0 0",
                     bus.req_ready, bus.rsp_valid, bus.alu_a, bus.flags_q, bus.rsp_tag);
        else n_pass++;
        m_flags = 4'd0;
        last_a = 32'd0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        logic [3:0] op;
        logic [31:0] b;
        for (int i = 0; i < 25; i++) begin
            op = 4'($urandom_range(0, 11));
            b = ($urandom_range(0, 3) == 0) ? 32'd0 : (($urandom_range(0, 1) == 1) ? 32'($urandom_range(1, 300)) : $urandom);
            run_op(op, (op == 4'd2) ? 32'($urandom_range(0, 70000)) : $urandom, b,
                   1'($urandom), 4'($urandom), $urandom_range(0, 3));
        end
    endtask

    initial begin
        bus.flush = 1'b0; bus.req_valid = 1'b0; bus.req_op = 4'd0; bus.req_a = 32'd0; bus.req_b = 32'd0;
        bus.req_set_flags = 1'b0; bus.req_tag = 4'd0; bus.rsp_ready = 1'b0;
        test_reset();
        test_add();
        test_sub();
        test_div();
        test_backpressure();
        test_flush();
        test_illegal();
        test_random();
        test_async_reset();
        test_add();
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Initiator side of the ALU datapath interface; it sequences operations into the combinational ALU and collects the results.
- Accepts operation requests over a valid/ready handshake and drives registered operands and opcode into the ALU.
- Holds them for the opcode's multicycle latency, then captures result and flags.
- Returns them over a valid/ready response channel and maintains the architectural NZCV flags register.
- Sits between decode/execute control and the ALU top level.

Parameters:
N, 32, operand/result width
TAG_W, 4, request tag width, returned unchanged with the response
LAT_FAST, 1, cycles operands are held for add/sub/mov (min 1)
LAT_MUL, 2, cycles held for mul (min 1)
LAT_DIV, 4, cycles held for div/mod (min 1)

Ports:
clk  in  1  clock; all state on rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous abort of any in-flight operation
req_valid  in  1  request present
req_ready  out  1  block can accept request
req_op  in  4  opcode
req_a  in  N  operand A
req_b  in  N  operand B
req_set_flags  in  1  update flags_q on completion
req_tag  in  TAG_W  request identifier
alu_a  out  N  registered ALU operand A
alu_b  out  N  registered ALU operand B
alu_op  out  4  registered ALU opcode
alu_result  in  N  ALU result (combinational from alu_a/alu_b/alu_op)
alu_flags  in  4  ALU flags {N,Z,C,V}
rsp_valid  out  1  response present
rsp_ready  in  1  consumer takes response
rsp_result  out  N  captured result
rsp_flags  out  4  captured flags
rsp_tag  out  TAG_W  tag of completed request
rsp_err  out  1  illegal opcode or divide by zero
flags_q  out  4  architectural flags {N,Z,C,V}

Behaviour:
- Reset: one clock `clk`; reset `rst_n` is asynchronous and active-low. While it is low:
  - state=IDLE;
  - req_ready=1 once released, rsp_valid=0;
  - alu_a/alu_b/rsp_result=0; alu_op=4'b0000; rsp_flags=0; rsp_tag=0; rsp_err=0; flags_q=4'b0000; counter=0.
- Opcodes: 0 add, 1 sub, 2 mul, 3 div, 4 mod, 5 mov; 6..15 illegal.
- FSM states:
  - IDLE: req_ready=1.
  - EXEC: req_ready=0; alu_* held stable.
  - DONE: req_ready=0; rsp_valid=1.
- IDLE, req_valid=1:
  - accept at edge k; alu_a/alu_b/alu_op <= req fields; tag and set_flags latched.
  - Counter <= LAT(op)-1; go to EXEC.
- EXEC: counter decrements each cycle. At the edge where counter==0:
  - rsp_result/rsp_flags <= alu_result/alu_flags; rsp_err=0;
  - go to DONE.
- Latency: rsp_valid rises at edge k+LAT(op), i.e. LAT cycles after acceptance.
- Illegal opcode: accepted; result captured after LAT_FAST; rsp_result=0, rsp_flags=0, rsp_err=1; alu_op driven as received.
- Div/mod with req_b==0: full LAT_DIV wait; rsp_result=0, rsp_flags=0, rsp_err=1.
- flags_q: updated to rsp_flags at the capture edge only if set_flags=1 and err=0; otherwise unchanged.
- DONE: rsp_* stable while rsp_valid=1 and rsp_ready=0. On rsp_valid & rsp_ready, go to IDLE next edge.
- No request is accepted in the same cycle as a response handshake, so peak throughput is one op per LAT+2 cycles.
- flush=1 (any state): next state IDLE; rsp_valid=0; the in-flight op is discarded, flags_q unchanged; alu_* keep their last values.
  - flush has priority over acceptance and capture in the same cycle.
  - flush in IDLE with req_valid=1: request not accepted.
- Async reset mid-EXEC/DONE: immediate return to reset values; the operation is lost.
- Widths: opcode/flags passed through unchanged; no arithmetic in this block apart from the b==0 check and the counter, which is sized to clog2(max LAT)+1.

Decomposition:
- Shared package alu_pkg holds:
  - opcode localparams OP_ADD..OP_MOV;
  - flag bit indices FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0;
  - enum state_t {IDLE, EXEC, DONE};
  - function op_latency(op).
- No sub-module required. An optional leaf alu_lat_counter (load/decrement/zero) is acceptable.

Test Plan:
- Reset: drive req_valid=1 with rst_n=0 -> req_ready=1 on release, rsp_valid=0, flags_q=0000; no acceptance during reset.
- Add with flags: op=0, a=5, b=3, set_flags=1, tag=7 -> rsp_valid 1 cycle after accept, rsp_result=8, rsp_flags=0000, rsp_tag=7, flags_q=0000.
- Sub: op=1, a=3, b=5, set_flags=1 -> rsp_result=32'hFFFFFFFE, rsp_flags[N]=1, flags_q[N]=1; req_ready=0 through DONE.
- Div latency and error: op=3, a=100, b=7 -> rsp_valid exactly 4 cycles after accept, result=14. Then op=4, b=0, set_flags=1 -> result=0, rsp_err=1, flags_q unchanged.
- Backpressure: hold rsp_ready=0 for 5 cycles after a mul (6*7) -> rsp_result=42 stable, req_ready=0. Then rsp_ready=1 -> next-cycle req_ready=1.
- Flush/illegal: assert flush 1 cycle into a div -> no rsp_valid, IDLE next cycle, flags_q unchanged. op=9 -> rsp_err=1, result 0 after 1 cycle.
